// File: rtl/dbus_pkg.sv
// ---------------------------------------------------------------------------
// dbus_pkg
// Shared definitions for the CPU data-bus arbiter: bus widths, the default
// peripheral page, the arbiter FSM encoding and the master request bundle.
// ---------------------------------------------------------------------------
package dbus_pkg;

    localparam int          DBUS_AW      = 32;
    localparam int          DBUS_DW      = 32;
    // addr[31:12] of the switch/LED/7-seg register page
    localparam logic [19:0] DBUS_IO_BASE = 20'hfffff;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        ACK   = 2'd3
    } dbus_state_t;

    // What a master presents in the grant cycle
    typedef struct packed {
        logic               wen;
        logic [DBUS_AW-1:0] addr;
        logic [DBUS_DW-1:0] wdata;
    } dbus_req_t;

    // Peripheral page accesses never wait, whatever the DRAM latency
    function automatic logic is_io_page(input logic [DBUS_AW-1:0] addr,
                                        input logic [19:0]        base);
        return addr[31:12] == base;
    endfunction

endpackage

// File: rtl/rr_pick2.sv
// ---------------------------------------------------------------------------
// rr_pick2
// Two-way round-robin picker, purely combinational.
//   req[1:0]  in   request from master 0 / master 1
//   last      in   index of the master served most recently
//   gnt       out  index of the winning master (meaningful when gnt_vld)
//   gnt_vld   out  at least one request present
// ---------------------------------------------------------------------------
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       gnt,
    output logic       gnt_vld
);

    always_comb begin
        gnt_vld = |req;
        // a lone request wins outright; on a tie the other master goes
        gnt     = req[1];
        if (req == 2'b11)
            gnt = ~last;
    end

endmodule

// File: rtl/dbus_arb.sv
// ---------------------------------------------------------------------------
// dbus_arb
// Shares the single decoded data-memory/peripheral port between the CPU data
// port (m0) and the debug/program loader (m1). One transaction at a time:
// IDLE (arbitrate + latch) -> ISSUE -> [WAIT for DRAM reads] -> ACK -> IDLE.
//
// Parameters
//   RD_LAT   DRAM read latency in cycles after address issue (0..3)
//   IO_BASE  addr[31:12] of the zero-wait peripheral page
// Ports
//   clk, rst                  clock, async active-high reset
//   mN_req/wen/addr/wdata     master requests, sampled only in the grant cycle
//   mN_ack                    one-cycle completion pulse
//   mN_rdata                  registered read data, held until the next read
//   bus_addr/wen/wdata        decoder side; bus_wen is high only in ISSUE
//   bus_rdata                 decoder read data
//   bus_owner                 master being served or last served
// ---------------------------------------------------------------------------
module dbus_arb
    import dbus_pkg::*;
#(
    parameter int          RD_LAT  = 1,
    parameter logic [19:0] IO_BASE = DBUS_IO_BASE
) (
    input  logic               clk,
    input  logic               rst,

    input  logic               m0_req,
    input  logic               m0_wen,
    input  logic [DBUS_AW-1:0] m0_addr,
    input  logic [DBUS_DW-1:0] m0_wdata,
    output logic               m0_ack,
    output logic [DBUS_DW-1:0] m0_rdata,

    input  logic               m1_req,
    input  logic               m1_wen,
    input  logic [DBUS_AW-1:0] m1_addr,
    input  logic [DBUS_DW-1:0] m1_wdata,
    output logic               m1_ack,
    output logic [DBUS_DW-1:0] m1_rdata,

    output logic [DBUS_AW-1:0] bus_addr,
    output logic               bus_wen,
    output logic [DBUS_DW-1:0] bus_wdata,
    input  logic [DBUS_DW-1:0] bus_rdata,
    output logic               bus_owner
);

    // WAIT runs RD_LAT cycles, counting down to 0; only loaded when RD_LAT>0
    localparam logic [1:0] CNT_LOAD = (RD_LAT > 0) ? 2'(RD_LAT - 1) : 2'd0;

    dbus_state_t             state;
    logic [1:0]              cnt;
    logic [1:0]              ack_q;
    logic [1:0][DBUS_DW-1:0] rdata_q;

    dbus_req_t [1:0] mst;
    logic            gnt;
    logic            gnt_vld;
    logic            zero_wait;

    assign mst[0] = '{wen: m0_wen, addr: m0_addr, wdata: m0_wdata};
    assign mst[1] = '{wen: m1_wen, addr: m1_addr, wdata: m1_wdata};

    rr_pick2 u_pick (
        .req     ({m1_req, m0_req}),
        .last    (bus_owner),
        .gnt     (gnt),
        .gnt_vld (gnt_vld)
    );

    // bus_addr is already the latched address by the time we are in ISSUE
    assign zero_wait = is_io_page(bus_addr, IO_BASE) || (RD_LAT == 0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            bus_addr  <= '0;
            bus_wdata <= '0;
            bus_wen   <= 1'b0;
            bus_owner <= 1'b1;      // m0 wins the first tie
            cnt       <= 2'd0;
            ack_q     <= 2'b00;
            rdata_q   <= '0;
        end else begin
            ack_q <= 2'b00;
            case (state)
                IDLE: begin
                    if (gnt_vld) begin
                        bus_addr  <= mst[gnt].addr;
                        bus_wdata <= mst[gnt].wdata;
                        bus_wen   <= mst[gnt].wen;
                        bus_owner <= gnt;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    // bus_wen holds the latched wen only in this state
                    bus_wen <= 1'b0;
                    if (bus_wen) begin
                        ack_q[bus_owner] <= 1'b1;
                        state            <= ACK;
                    end else if (zero_wait) begin
                        rdata_q[bus_owner] <= bus_rdata;
                        ack_q[bus_owner]   <= 1'b1;
                        state              <= ACK;
                    end else begin
                        cnt   <= CNT_LOAD;
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt == 2'd0) begin
                        rdata_q[bus_owner] <= bus_rdata;
                        ack_q[bus_owner]   <= 1'b1;
                        state              <= ACK;
                    end else begin
                        cnt <= cnt - 2'd1;
                    end
                end
                ACK: begin
                    // mandatory turnaround; new requests are seen in IDLE
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign m0_ack   = ack_q[0];
    assign m1_ack   = ack_q[1];
    assign m0_rdata = rdata_q[0];
    assign m1_rdata = rdata_q[1];

endmodule

// File: tb/tb_dbus_arb.sv
// Bench for dbus_arb: directed scenarios plus random two-master traffic,
// checked every cycle against a transaction-level schedule model.
module tb_dbus_arb;

    localparam int          RD_LAT  = 1;
    localparam logic [19:0] IO_PAGE = 20'hfffff;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        m0_req = 1'b0, m1_req = 1'b0;
    logic        m0_wen = 1'b0, m1_wen = 1'b0;
    logic [31:0] m0_addr = '0, m1_addr = '0, m0_wdata = '0, m1_wdata = '0;
    logic        m0_ack, m1_ack;
    logic [31:0] m0_rdata, m1_rdata;
    logic [31:0] bus_addr, bus_wdata;
    logic        bus_wen, bus_owner;
    logic [31:0] bus_rdata = '0;

    always #5 clk = ~clk;

    dbus_arb #(.RD_LAT(RD_LAT), .IO_BASE(IO_PAGE)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_wen(m0_wen), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ack(m0_ack), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_wen(m1_wen), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ack(m1_ack), .m1_rdata(m1_rdata),
        .bus_addr(bus_addr), .bus_wen(bus_wen), .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata), .bus_owner(bus_owner)
    );

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            if (miscompares <= 30)
                $display("FAIL %s cyc=%0d got=%h want=%h", tag, cyc, obs, exp);
        end
    endtask

    // master behaviour: 0 idle, 1 requesting, 2 granted and awaiting ack
    int          ms[2];
    logic        mwen[2];
    logic [31:0] maddr[2], mwdata[2], mdata[2];
    int          auto_pct = 0;

    // schedule model: one transaction in flight, known by its cycle numbers
    int          next_idle;
    logic        last;
    bit          have;
    int          t_issue, t_ack;
    logic        t_own, t_wen;
    logic [31:0] t_addr, t_wdata, t_data;
    logic [31:0] exp_addr, exp_wdata;
    logic        exp_own;
    logic [31:0] exp_rd[2];

    task automatic model_reset();
        next_idle = 0; last = 1'b1; have = 0;
        t_issue = -10; t_ack = -10;
        exp_addr = '0; exp_wdata = '0; exp_own = 1'b1;
        exp_rd[0] = '0; exp_rd[1] = '0;
        ms[0] = 0; ms[1] = 0;
    endtask

    task automatic post(input int m, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] rd);
        ms[m] = 1; mwen[m] = w; maddr[m] = a; mwdata[m] = d; mdata[m] = rd;
    endtask

    task automatic rand_post(input int m);
        logic [31:0] a;
        if ($urandom_range(0, 2) == 0) a = 32'hffff_f000 + 32'($urandom_range(0, 2));
        else                           a = $urandom & 32'h0000_fffc;
        post(m, 1'($urandom_range(0, 1)), a, $urandom, $urandom);
    endtask

    task automatic chk_reset_vals();
        chk("rst_m0_ack",    32'(m0_ack),    32'd0);
        chk("rst_m1_ack",    32'(m1_ack),    32'd0);
        chk("rst_bus_wen",   32'(bus_wen),   32'd0);
        chk("rst_bus_owner", 32'(bus_owner), 32'd1);
        chk("rst_bus_addr",  bus_addr,       32'd0);
        chk("rst_bus_wdata", bus_wdata,      32'd0);
        chk("rst_m0_rdata",  m0_rdata,       32'd0);
        chk("rst_m1_rdata",  m1_rdata,       32'd0);
    endtask

    task automatic step();
        logic        q[2], w[2];
        logic [31:0] a[2], d[2];
        logic        win;
        @(negedge clk);
        cyc++;
        // expected view of this cycle
        if (have && cyc == t_issue) begin
            exp_addr = t_addr; exp_wdata = t_wdata; exp_own = t_own;
        end
        if (have && cyc == t_ack && !t_wen) exp_rd[t_own] = t_data;
        chk("m0_ack",    32'(m0_ack),  32'(have && cyc == t_ack && t_own == 1'b0));
        chk("m1_ack",    32'(m1_ack),  32'(have && cyc == t_ack && t_own == 1'b1));
        chk("bus_wen",   32'(bus_wen), 32'(have && cyc == t_issue && t_wen));
        chk("bus_addr",  bus_addr,     exp_addr);
        chk("bus_wdata", bus_wdata,    exp_wdata);
        chk("bus_owner", 32'(bus_owner), 32'(exp_own));
        chk("m0_rdata",  m0_rdata,     exp_rd[0]);
        chk("m1_rdata",  m1_rdata,     exp_rd[1]);
        // masters: release on ack, maybe start something new
        for (int m = 0; m < 2; m++) begin
            if (ms[m] == 2 && have && cyc == t_ack && t_own == 1'(m)) ms[m] = 0;
            if (ms[m] == 0 && int'($urandom_range(0, 99)) < auto_pct) rand_post(m);
            if (ms[m] == 1) begin
                q[m] = 1'b1; w[m] = mwen[m]; a[m] = maddr[m]; d[m] = mwdata[m];
            end else begin
                // after grant (or idle) the pins are junk; req may drop or wiggle
                q[m] = (ms[m] == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
                w[m] = 1'($urandom_range(0, 1)); a[m] = $urandom; d[m] = $urandom;
            end
        end
        m0_req = q[0]; m0_wen = w[0]; m0_addr = a[0]; m0_wdata = d[0];
        m1_req = q[1]; m1_wen = w[1]; m1_addr = a[1]; m1_wdata = d[1];
        // arbitration happens only in an idle cycle
        if (cyc >= next_idle && (ms[0] == 1 || ms[1] == 1)) begin
            if (ms[0] == 1 && ms[1] == 1) win = ~last;
            else                          win = (ms[1] == 1);
            last = win; ms[win] = 2; have = 1;
            t_own = win; t_wen = mwen[win]; t_addr = maddr[win];
            t_wdata = mwdata[win]; t_data = mdata[win];
            t_issue = cyc + 1;
            if (t_wen || t_addr[31:12] == IO_PAGE || RD_LAT == 0) t_ack = cyc + 2;
            else                                                  t_ack = cyc + 2 + RD_LAT;
            next_idle = t_ack + 1;
        end
        // decoder returns the read data only in the cycle it must be captured
        bus_rdata = (have && !t_wen && cyc == t_ack - 1) ? t_data : $urandom;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        model_reset();
        #12;
        chk_reset_vals();
        rst = 1'b0;

        // m0 write, m0 DRAM read, m1 peripheral read
        post(0, 1'b1, 32'h0000_0010, 32'hdead_beef, 32'h0);
        run(5);
        post(0, 1'b0, 32'h0000_0020, 32'h0, 32'h1234_5678);
        run(6);
        post(1, 1'b0, 32'hffff_f000, 32'h0, 32'h00ab_cdef);
        run(5);

        // continuous tie: both masters re-request immediately
        auto_pct = 100;
        run(30);
        auto_pct = 0;
        run(12);

        // m1 write arrives while m0's read sits in WAIT
        post(0, 1'b0, 32'h0000_0040, 32'h0, 32'h55aa_55aa);
        run(2);
        post(1, 1'b1, 32'h0000_0080, 32'h1111_2222, 32'h0);
        run(9);

        // random mixed traffic
        auto_pct = 40;
        run(3000);
        auto_pct = 0;
        run(12);

        // reset pulse during WAIT of an m0 read
        post(0, 1'b0, 32'h0000_0020, 32'h0, 32'h9999_0000);
        run(3);
        #2 rst = 1'b1;
        #1 chk_reset_vals();
        @(posedge clk);
        #1 chk_reset_vals();
        model_reset();
        rst = 1'b0;
        post(0, 1'b1, 32'h0000_0004, 32'hcafe_f00d, 32'h0);
        run(5);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dbus_arb.md
# dbus_arb

Two-master arbiter and sequencer for the CPU data bus that feeds the memory-mapped data-memory/peripheral decoder (DRAM below 0xFFFFF000; switches, LEDs and 7-segment registers at 0xFFFFF000–0xFFFFF002). It shares that single decoded port between the CPU data port (m0) and the debug/program loader (m1) using round-robin arbitration. It issues one transaction at a time, handles the read latency, and returns registered read data with a one-cycle ack pulse.

## Interface
Parameters:
- `RD_LAT`, default 1: cycles from address issue to valid `bus_rdata` for DRAM reads; legal range 0–3.
- `IO_BASE`, default 20'hfffff: value of `addr[31:12]` that selects the peripheral page. Peripheral reads are always zero-wait.

Ports:
- `clk`  in  1: single clock; all state updates on its rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `m0_req`, `m1_req`  in  1: transaction request from each master.
- `m0_wen`, `m1_wen`  in  1: 1 = write, 0 = read.
- `m0_addr`, `m1_addr`  in  32: byte address.
- `m0_wdata`, `m1_wdata`  in  32: write data.
- `m0_ack`, `m1_ack`  out  1: one-cycle completion pulse.
- `m0_rdata`, `m1_rdata`  out  32: registered read data, valid when the matching ack is high. Holds its value until the next read completes for that master.
- `bus_addr`  out  32: address to the decoder.
- `bus_wen`  out  1: write strobe to the decoder.
- `bus_wdata`  out  32: write data to the decoder.
- `bus_rdata`  in  32: read data from the decoder.
- `bus_owner`  out  1: index of the master being served or last served.

## Operation
FSM states: IDLE, ISSUE, WAIT, ACK.
- **IDLE**
  - No requests: stay in IDLE.
  - One request: grant that master.
  - Both requests: grant the master not in `bus_owner`.
  - On grant: latch the winner's addr/wen/wdata into `bus_*`, set `bus_owner`, go to ISSUE.
- **ISSUE**
  - `bus_wen` equals the latched wen. This is the only state in which `bus_wen` can be 1.
  - Write: go to ACK.
  - Read with a zero-wait target: capture `bus_rdata` at the end of ISSUE, go to ACK. A target is zero-wait when `addr[31:12]==IO_BASE` or `RD_LAT==0`.
  - Otherwise: load the wait counter with `RD_LAT-1`, go to WAIT.
- **WAIT**
  - Address held, `bus_wen` = 0.
  - Counter decrements each cycle. At 0, capture `bus_rdata` into the owner's rdata register and go to ACK.
- **ACK**
  - Owner's ack = 1 for exactly this cycle, then go to IDLE.
  - Any req high in the following IDLE cycle is a new transaction.
- Master inputs are sampled only in the IDLE grant cycle. Later changes, including req dropping early, do not affect the transaction; it still completes and acks.
- The loser of arbitration keeps req high and is granted in the next IDLE. A master waits at most one other transaction.
- `bus_addr` and `bus_wdata` hold their last value in IDLE. The decoder sees no write because `bus_wen` = 0.

## Timing
- Reset values:
  - state = IDLE.
  - `bus_addr`, `bus_wdata`, `m0_rdata`, `m1_rdata` = 0.
  - `bus_wen`, `m0_ack`, `m1_ack` = 0.
  - `bus_owner` = 1, so m0 wins the first tie.
- Latency is counted from the cycle the request is sampled in IDLE (cycle 0):
  - Write: `bus_wen` high in cycle 1, ack in cycle 2.
  - Zero-wait read: ack in cycle 2.
  - DRAM read: ack in cycle 2+`RD_LAT`.
- Throughput: one transaction per 3 cycles for writes and zero-wait reads; ACK→IDLE is mandatory.
- Reset asserted in any state forces reset values immediately, without waiting for a clock edge.
  - The in-flight transaction is dropped with no ack and no further strobe.
  - The first sampled request after reset release is served normally.
- Ack and its rdata are both registered. rdata is stable in the ack cycle and afterwards.

## Structure
- Shared package `dbus_pkg`:
  - state encoding constants (IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2, ACK=2'd3);
  - `IO_BASE` default;
  - `DBUS_AW`/`DBUS_DW` = 32.
- One sub-module, `rr_pick2`. Inputs: `req[1:0]`, last owner. Outputs: grant index, grant valid. It is purely combinational.
- The FSM, wait counter and latch registers live in the top module.

## Test plan
- **m0 write:** m0 writes 0xDEADBEEF to 0x00000010 with m1 idle. Required: `bus_wen`=1 only in cycle 1 with `bus_addr`=0x10 and `bus_wdata`=0xDEADBEEF, `m0_ack` in cycle 2.
- **m0 DRAM read:** m0 reads 0x00000020 with `RD_LAT`=1 and the model returning 0x12345678. Required: `bus_wen` never high, `m0_ack` in cycle 3, `m0_rdata`=0x12345678 held after ack.
- **m1 peripheral read:** m1 reads 0xFFFFF000 with `bus_rdata`=0x00ABCDEF. Required: `m1_ack` in cycle 2, `m1_rdata`=0x00ABCDEF, `bus_owner`=1.
- **Continuous tie:** both masters hold req from reset. Required: grants alternate m0, m1, m0, m1, and each ack goes only to the owner.
- **Arrival mid-transaction:** m1 raises a write while m0's read is in WAIT. Required: m1 waits, issues in the cycle after the IDLE following m0's ack, and m0's rdata is unaffected.
- **Reset mid-transaction:** `rst` pulses during WAIT of an m0 read. Required: all outputs return to reset values in that cycle with no ack. After release, an m0 write to 0x4 completes with ack in cycle 2.
